// File: rtl/ff2_sync_if.sv
// ---------------------------------------------------------------------------
// ff2_sync_if
//   Bundles the level input and the synchronized outputs of ff2_sync.
//
//   Signals (all WIDTH bits):
//     in_data   asynchronous level from the source domain
//     out_data  synchronized level (last synchronizer stage)
//     out_rise  one-cycle pulse per bit on a 0->1 change of out_data
//     out_fall  one-cycle pulse per bit on a 1->0 change of out_data
//
//   Modports:
//     master  source side: drives in_data and observes the results
//     slave   synchronizer side: receives in_data and drives the results
// ---------------------------------------------------------------------------
interface ff2_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_rise;
    logic [WIDTH-1:0] out_fall;

    modport master (
        output in_data,
        input  out_data,
        input  out_rise,
        input  out_fall
    );

    modport slave (
        input  in_data,
        output out_data,
        output out_rise,
        output out_fall
    );
endinterface

// File: rtl/ff2_sync.sv
// ---------------------------------------------------------------------------
// ff2_sync
//   Multi-flop synchronizer for level signals crossing into the clk domain,
//   with rise/fall pulse detection on the synchronized level.
//
//   Parameters:
//     WIDTH        bits synchronized in parallel, each independently (1..32)
//     STAGES       synchronizer depth (2..4); smaller values behave as 2
//     EDGE         0 = all flops act on the rising clk edge,
//                  1 = all flops act on the falling clk edge
//     RESET_VALUE  reset and power-up value of every stage and the history
//
//   Ports:
//     clk  destination-domain clock
//     rst  synchronous active-high reset, sampled on the selected clk edge
//     bus  ff2_sync_if.slave: in_data in; out_data / out_rise / out_fall out
//
//   A change on in_data that is stable across a sampling edge reaches
//   out_data after exactly STAGES active edges; out_rise / out_fall are high
//   for the single cycle in which out_data changes. Bits are not coherent
//   with each other, and pulses shorter than a clk period may be lost.
// ---------------------------------------------------------------------------
module ff2_sync #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter int               EDGE        = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic       clk,
    input  logic       rst,
    ff2_sync_if.slave  bus
);

    // Fewer than two flops gives no metastability protection at all.
    localparam int STAGES_C = (STAGES < 2) ? 2 : STAGES;

    // Flop outputs of the chain; element 0 is the only flop that sees the
    // asynchronous input.
    logic [WIDTH-1:0] stage_q [STAGES_C];

    // Previous value of out_data for the edge detector.
    logic [WIDTH-1:0] hist_reg = RESET_VALUE;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES_C; gi++) begin : g_stage
            // The declaration initializer gives the power-up value, so the
            // block is usable with rst tied low. The attributes keep the
            // chain as plain adjacent flops: no SRL packing, no retiming.
            (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
            logic [WIDTH-1:0] stage_reg = RESET_VALUE;
            logic [WIDTH-1:0] stage_next;

            if (gi == 0) begin : g_first
                assign stage_next = bus.in_data;
            end else begin : g_chain
                assign stage_next = stage_q[gi-1];
            end

            if (EDGE == 0) begin : g_pos
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= RESET_VALUE;
                    end else begin
                        stage_reg <= stage_next;
                    end
                end
            end else begin : g_neg
                always_ff @(negedge clk) begin
                    if (rst) begin
                        stage_reg <= RESET_VALUE;
                    end else begin
                        stage_reg <= stage_next;
                    end
                end
            end

            assign stage_q[gi] = stage_reg;
        end

        if (EDGE == 0) begin : g_hist_pos
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_reg <= RESET_VALUE;
                end else begin
                    hist_reg <= stage_q[STAGES_C-1];
                end
            end
        end else begin : g_hist_neg
            always_ff @(negedge clk) begin
                if (rst) begin
                    hist_reg <= RESET_VALUE;
                end else begin
                    hist_reg <= stage_q[STAGES_C-1];
                end
            end
        end
    endgenerate

    // out_data comes straight off the last flop. Both detector inputs are
    // flops updated on the same edge, so the pulses are glitch-free and last
    // exactly one period. Reset loads out_data and hist with the same value,
    // so no pulse appears in the first cycle after reset.
    assign bus.out_data = stage_q[STAGES_C-1];
    assign bus.out_rise = stage_q[STAGES_C-1] & ~hist_reg;
    assign bus.out_fall = ~stage_q[STAGES_C-1] & hist_reg;

endmodule

// File: tb/tb_ff2_sync.sv
// ---------------------------------------------------------------------------
// tb_ff2_sync
//   Directed checks of ff2_sync in several configurations:
//     u_pos  defaults (rising edge, 2 stages)
//     u_neg  EDGE=1 (falling edge)
//     u_s3   STAGES=3, WIDTH=4, RESET_VALUE=4'hA
//     u_pu   WIDTH=4, RESET_VALUE=4'h6, rst tied low (power-up value)
//     u_as   defaults on a 355 ns clock, fed from a 200 ns source clock
// ---------------------------------------------------------------------------
module tb_ff2_sync;

    logic clk   = 1'b0;
    logic clk_a = 1'b0;
    logic clk_s = 1'b0;

    always #5   clk   = ~clk;
    always #177.5 clk_a = ~clk_a;
    always #100 clk_s = ~clk_s;

    logic rst_pos = 1'b1;
    logic rst_neg = 1'b1;
    logic rst_s3  = 1'b1;
    logic rst_as  = 1'b1;
    logic rst_pu  = 1'b0;

    ff2_sync_if #(.WIDTH(1)) bus_pos ();
    ff2_sync_if #(.WIDTH(1)) bus_neg ();
    ff2_sync_if #(.WIDTH(4)) bus_s3  ();
    ff2_sync_if #(.WIDTH(4)) bus_pu  ();
    ff2_sync_if #(.WIDTH(1)) bus_as  ();

    ff2_sync #(.WIDTH(1)) u_pos (.clk(clk), .rst(rst_pos), .bus(bus_pos));
    ff2_sync #(.WIDTH(1), .EDGE(1)) u_neg (.clk(clk), .rst(rst_neg), .bus(bus_neg));
    ff2_sync #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'hA)) u_s3 (.clk(clk), .rst(rst_s3), .bus(bus_s3));
    ff2_sync #(.WIDTH(4), .RESET_VALUE(4'h6)) u_pu (.clk(clk), .rst(rst_pu), .bus(bus_pu));
    ff2_sync #(.WIDTH(1)) u_as (.clk(clk_a), .rst(rst_as), .bus(bus_as));

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    // Edge pulses of the asynchronous instance, sampled mid-cycle.
    always @(negedge clk_a) begin
        if (!rst_as) begin
            pulse_cnt = pulse_cnt + int'(bus_as.out_rise) + int'(bus_as.out_fall);
        end
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %-20s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic target;
        logic seen;
        int   p0;

        bus_pos.in_data = 1'b0;
        bus_neg.in_data = 1'b1;
        bus_s3.in_data  = 4'h5;
        bus_pu.in_data  = 4'h6;
        bus_as.in_data  = 1'b0;

        // ---------------- power-up without reset ----------------
        #1;
        check("pu_init_data", bus_pu.out_data, 4'h6);
        check("pu_init_rise", bus_pu.out_rise, 4'h0);
        check("pu_init_fall", bus_pu.out_fall, 4'h0);
        wait_pos();
        wait_pos();
        check("pu_hold_data", bus_pu.out_data, 4'h6);
        bus_pu.in_data = 4'h9;
        wait_pos();
        check("pu_lat1_data", bus_pu.out_data, 4'h6);
        wait_pos();
        check("pu_lat2_data", bus_pu.out_data, 4'h9);
        check("pu_lat2_rise", bus_pu.out_rise, 4'h9);
        check("pu_lat2_fall", bus_pu.out_fall, 4'h6);
        wait_pos();
        check("pu_after_rise", bus_pu.out_rise, 4'h0);
        check("pu_after_fall", bus_pu.out_fall, 4'h0);

        // ---------------- EDGE=0, defaults ----------------
        wait_pos();
        check("pos_rst_data", 4'(bus_pos.out_data), 4'h0);
        check("pos_rst_rise", 4'(bus_pos.out_rise), 4'h0);
        check("pos_rst_fall", 4'(bus_pos.out_fall), 4'h0);
        rst_pos = 1'b0;
        wait_pos();                       // edge N
        bus_pos.in_data = 1'b1;
        wait_pos();                       // N+1: only stage0 holds 1
        check("pos_n1_data", 4'(bus_pos.out_data), 4'h0);
        check("pos_n1_rise", 4'(bus_pos.out_rise), 4'h0);
        wait_pos();                       // N+2
        check("pos_n2_data", 4'(bus_pos.out_data), 4'h1);
        check("pos_n2_rise", 4'(bus_pos.out_rise), 4'h1);
        check("pos_n2_fall", 4'(bus_pos.out_fall), 4'h0);
        wait_pos();
        check("pos_n3_data", 4'(bus_pos.out_data), 4'h1);
        check("pos_n3_rise", 4'(bus_pos.out_rise), 4'h0);
        bus_pos.in_data = 1'b0;
        wait_pos();
        check("pos_f1_data", 4'(bus_pos.out_data), 4'h1);
        wait_pos();
        check("pos_f2_data", 4'(bus_pos.out_data), 4'h0);
        check("pos_f2_fall", 4'(bus_pos.out_fall), 4'h1);
        check("pos_f2_rise", 4'(bus_pos.out_rise), 4'h0);
        wait_pos();
        check("pos_f3_fall", 4'(bus_pos.out_fall), 4'h0);

        // reset while a 1 sits in stage0
        bus_pos.in_data = 1'b1;
        wait_pos();
        rst_pos = 1'b1;
        wait_pos();
        check("pos_mid_rst_data", 4'(bus_pos.out_data), 4'h0);
        check("pos_mid_rst_rise", 4'(bus_pos.out_rise), 4'h0);
        rst_pos = 1'b0;
        wait_pos();
        check("pos_rel1_data", 4'(bus_pos.out_data), 4'h0);
        wait_pos();
        check("pos_rel2_data", 4'(bus_pos.out_data), 4'h1);
        check("pos_rel2_rise", 4'(bus_pos.out_rise), 4'h1);
        wait_pos();
        check("pos_rel3_rise", 4'(bus_pos.out_rise), 4'h0);

        // ---------------- EDGE=1 ----------------
        wait_neg();
        check("neg_rst_data", 4'(bus_neg.out_data), 4'h0);
        rst_neg = 1'b0;
        wait_neg();
        wait_neg();
        check("neg_up_data", 4'(bus_neg.out_data), 4'h1);
        check("neg_up_rise", 4'(bus_neg.out_rise), 4'h1);
        wait_neg();
        check("neg_up2_rise", 4'(bus_neg.out_rise), 4'h0);
        bus_neg.in_data = 1'b0;           // between falling edges
        wait_pos();
        check("neg_pe0_data", 4'(bus_neg.out_data), 4'h1);
        wait_neg();
        check("neg_ne1_data", 4'(bus_neg.out_data), 4'h1);
        wait_pos();
        check("neg_pe1_fall", 4'(bus_neg.out_fall), 4'h0);
        wait_neg();
        check("neg_ne2_data", 4'(bus_neg.out_data), 4'h0);
        check("neg_ne2_fall", 4'(bus_neg.out_fall), 4'h1);
        wait_pos();                       // rising edge must not end the pulse
        check("neg_pe2_data", 4'(bus_neg.out_data), 4'h0);
        check("neg_pe2_fall", 4'(bus_neg.out_fall), 4'h1);
        wait_neg();
        check("neg_ne3_fall", 4'(bus_neg.out_fall), 4'h0);
        bus_neg.in_data = 1'b1;
        wait_neg();
        wait_neg();
        check("neg_back_data", 4'(bus_neg.out_data), 4'h1);
        rst_neg = 1'b1;                   // reset only acts on a falling edge
        wait_pos();
        check("neg_rst_pe_data", 4'(bus_neg.out_data), 4'h1);
        wait_neg();
        check("neg_rst_ne_data", 4'(bus_neg.out_data), 4'h0);
        check("neg_rst_ne_fall", 4'(bus_neg.out_fall), 4'h0);

        // ---------------- STAGES=3, WIDTH=4, RESET_VALUE=A ----------------
        check("s3_rst_data", bus_s3.out_data, 4'hA);
        check("s3_rst_rise", bus_s3.out_rise, 4'h0);
        check("s3_rst_fall", bus_s3.out_fall, 4'h0);
        wait_pos();
        rst_s3 = 1'b0;
        wait_pos();
        check("s3_e1_data", bus_s3.out_data, 4'hA);
        check("s3_e1_rise", bus_s3.out_rise, 4'h0);
        wait_pos();
        check("s3_e2_data", bus_s3.out_data, 4'hA);
        wait_pos();
        check("s3_e3_data", bus_s3.out_data, 4'h5);
        check("s3_e3_rise", bus_s3.out_rise, 4'h5);
        check("s3_e3_fall", bus_s3.out_fall, 4'hA);
        wait_pos();
        check("s3_e4_rise", bus_s3.out_rise, 4'h0);
        check("s3_e4_fall", bus_s3.out_fall, 4'h0);

        // ---------------- asynchronous hold-until-ack toggles ----------------
        @(posedge clk_a);
        #1;
        rst_as = 1'b0;
        target = 1'b0;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_s);
            #($urandom_range(0, 150));
            target = ~target;
            bus_as.in_data = target;
            p0 = pulse_cnt;
            seen = 1'b0;
            // at most STAGES+1 destination periods plus the half-period offset
            for (int k = 0; k < 4 && !seen; k++) begin
                @(negedge clk_a);
                #1;
                if (bus_as.out_data === target) seen = 1'b1;
            end
            check($sformatf("as%0d_seen", i), 4'(seen), 4'h1);
            @(negedge clk_a);
            #1;
            check($sformatf("as%0d_pulses", i), 4'(pulse_cnt - p0), 4'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
